// File: rtl/flexdpe_cmd_sequencer_if.sv
// Command-push and flexdpe-issue signal bundle for the flexdpe command sequencer.
// master = controller/DMA side (pushes commands, observes beats); slave = sequencer.
interface flexdpe_cmd_sequencer_if #(
    parameter int unsigned IN_DATA_TYPE = 16,
    parameter int unsigned NUM_PES      = 32,
    parameter int unsigned LOG2_PES     = 5
);
    localparam int unsigned DATA_W = NUM_PES * IN_DATA_TYPE;
    localparam int unsigned IDX_W  = NUM_PES * LOG2_PES;

    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_stationary;
    logic [DATA_W-1:0] i_cmd_data;
    logic [IDX_W-1:0]  i_cmd_dest;
    logic [IDX_W-1:0]  i_cmd_vn;

    logic              o_data_valid;
    logic              o_stationary;
    logic [DATA_W-1:0] o_data_bus;
    logic [IDX_W-1:0]  o_dest_bus;
    logic [IDX_W-1:0]  o_vn_seperator;

    modport master (
        output i_cmd_valid, i_cmd_stationary, i_cmd_data, i_cmd_dest, i_cmd_vn,
        input  o_cmd_ready, o_data_valid, o_stationary, o_data_bus, o_dest_bus, o_vn_seperator
    );

    modport slave (
        input  i_cmd_valid, i_cmd_stationary, i_cmd_data, i_cmd_dest, i_cmd_vn,
        output o_cmd_ready, o_data_valid, o_stationary, o_data_bus, o_dest_bus, o_vn_seperator
    );
endinterface

// File: rtl/flexdpe_cmd_sequencer.sv
// Buffers stationary/streaming flexdpe commands in a FIFO and replays them as registered
// beats, draining the flexdpe pipeline before any stationary reload and before going idle.
module flexdpe_cmd_sequencer #(
    parameter int unsigned IN_DATA_TYPE = 16,
    parameter int unsigned NUM_PES      = 32,
    parameter int unsigned LOG2_PES     = 5,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned LOG2_DEPTH   = 3,
    parameter int unsigned DRAIN_CYCLES = 12,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    flexdpe_cmd_sequencer_if.slave   cmd_if,
    input  logic                     i_start,
    input  logic                     i_stall,
    output logic                     o_busy,
    output logic [LOG2_DEPTH:0]      o_fifo_count,
    output logic [CNT_W-1:0]         o_issue_count,
    output logic                     o_error
);
    localparam int unsigned DATA_W  = NUM_PES * IN_DATA_TYPE;
    localparam int unsigned IDX_W   = NUM_PES * LOG2_PES;
    localparam int unsigned ENTRY_W = 1 + DATA_W + 2 * IDX_W;
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [DRAIN_W-1:0]      drain_q, drain_d;
    logic                    loaded_q, loaded_d;
    logic                    streamed_q, streamed_d;
    logic                    error_q, error_d;

    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LOG2_DEPTH:0]     count_q, count_d;

    logic                    valid_q, stat_q;
    logic [DATA_W-1:0]       data_q;
    logic [IDX_W-1:0]        dest_q, vn_q;
    logic [CNT_W-1:0]        issue_q;

    logic                    cmd_ready, push, pop, beat, fifo_empty;
    logic [ENTRY_W-1:0]      head;
    logic                    head_stat;
    logic [DATA_W-1:0]       head_data;
    logic [IDX_W-1:0]        head_dest, head_vn;

    assign cmd_ready  = count_q < (LOG2_DEPTH+1)'(DEPTH);
    assign push       = cmd_if.i_cmd_valid && cmd_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign {head_stat, head_data, head_dest, head_vn} = head;

    // Issue FSM: next-state, pop/beat decisions and hazard flags
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        loaded_d   = loaded_q;
        streamed_d = streamed_q;
        error_d    = error_q;
        pop        = 1'b0;
        beat       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !fifo_empty) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (!i_stall) begin
                    if (fifo_empty || (head_stat && streamed_q)) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                    end else if (head_stat) begin
                        pop      = 1'b1;
                        beat     = 1'b1;
                        loaded_d = 1'b1;
                    end else if (!loaded_q) begin
                        pop     = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        pop        = 1'b1;
                        beat       = 1'b1;
                        streamed_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    streamed_d = 1'b0;
                    state_d    = fifo_empty ? ST_IDLE : ST_STREAM;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (LOG2_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG2_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array carries no reset; entries are only read while occupied
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_if.i_cmd_stationary, cmd_if.i_cmd_data,
                                      cmd_if.i_cmd_dest, cmd_if.i_cmd_vn};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            loaded_q   <= 1'b0;
            streamed_q <= 1'b0;
            error_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            stat_q     <= 1'b0;
            data_q     <= '0;
            dest_q     <= '0;
            vn_q       <= '0;
            issue_q    <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            loaded_q   <= loaded_d;
            streamed_q <= streamed_d;
            error_q    <= error_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + LOG2_DEPTH'(1);
            // Non-beat cycles drive every bus to zero
            valid_q    <= beat;
            stat_q     <= beat && head_stat;
            data_q     <= beat ? head_data : '0;
            dest_q     <= beat ? head_dest : '0;
            vn_q       <= beat ? head_vn   : '0;
            issue_q    <= issue_q + CNT_W'(beat);
        end
    end

    assign cmd_if.o_cmd_ready    = cmd_ready;
    assign cmd_if.o_data_valid   = valid_q;
    assign cmd_if.o_stationary   = stat_q;
    assign cmd_if.o_data_bus     = data_q;
    assign cmd_if.o_dest_bus     = dest_q;
    assign cmd_if.o_vn_seperator = vn_q;
    assign o_busy                = (state_q != ST_IDLE);
    assign o_fifo_count          = count_q;
    assign o_issue_count         = issue_q;
    assign o_error               = error_q;
endmodule

// File: tb/tb_flexdpe_cmd_sequencer.sv
// Randomised and directed bench for flexdpe_cmd_sequencer against a queue-based
// cycle reference model; every output is compared on each falling clock edge.
module tb_flexdpe_cmd_sequencer;
    localparam int unsigned IN_DATA_TYPE = 16;
    localparam int unsigned NUM_PES      = 32;
    localparam int unsigned LOG2_PES     = 5;
    localparam int unsigned DEPTH        = 8;
    localparam int unsigned LOG2_DEPTH   = 3;
    localparam int unsigned DRAIN_CYCLES = 12;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned DATA_W       = NUM_PES * IN_DATA_TYPE;
    localparam int unsigned IDX_W        = NUM_PES * LOG2_PES;

    localparam int M_IDLE = 0, M_STREAM = 1, M_DRAIN = 2;

    typedef struct {
        logic              s;
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  dst;
        logic [IDX_W-1:0]  vn;
    } cmd_t;

    logic clk, rst, start, stall;
    logic busy, error;
    logic [LOG2_DEPTH:0] fifo_count;
    logic [CNT_W-1:0]    issue_count;

    flexdpe_cmd_sequencer_if #(
        .IN_DATA_TYPE(IN_DATA_TYPE), .NUM_PES(NUM_PES), .LOG2_PES(LOG2_PES)
    ) cif ();

    flexdpe_cmd_sequencer #(
        .IN_DATA_TYPE(IN_DATA_TYPE), .NUM_PES(NUM_PES), .LOG2_PES(LOG2_PES),
        .DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cmd_if(cif.slave), .i_start(start), .i_stall(stall),
        .o_busy(busy), .o_fifo_count(fifo_count), .o_issue_count(issue_count), .o_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: the FIFO is a plain queue, drain is "cycles left"
    cmd_t              mq[$];
    int                m_mode, m_drain_left;
    bit                m_loaded, m_streamed, m_err;
    logic [CNT_W-1:0]  m_icnt;
    logic              m_valid, m_stat;
    logic [DATA_W-1:0] m_data;
    logic [IDX_W-1:0]  m_dst, m_vn;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_mode = M_IDLE; m_drain_left = 0; m_loaded = 0; m_streamed = 0; m_err = 0;
            m_icnt = '0; m_valid = 0; m_stat = 0; m_data = '0; m_dst = '0; m_vn = '0;
        end else begin
            int   sz;
            bit   do_push, do_pop, do_beat;
            cmd_t h, nc;
            sz = mq.size();
            do_push = cif.i_cmd_valid && (sz < int'(DEPTH));
            do_pop = 0; do_beat = 0;
            h = '{s: 1'b0, d: '0, dst: '0, vn: '0};
            if (sz > 0) h = mq[0];
            case (m_mode)
                M_IDLE: if (start && sz > 0) m_mode = M_STREAM;
                M_STREAM: if (!stall) begin
                    if (sz == 0 || (h.s && m_streamed)) begin
                        m_mode = M_DRAIN; m_drain_left = DRAIN_CYCLES;
                    end else if (h.s) begin
                        do_pop = 1; do_beat = 1; m_loaded = 1;
                    end else if (!m_loaded) begin
                        do_pop = 1; m_err = 1;
                    end else begin
                        do_pop = 1; do_beat = 1; m_streamed = 1;
                    end
                end
                default: begin
                    m_drain_left--;
                    if (m_drain_left == 0) begin
                        m_streamed = 0;
                        m_mode = (sz > 0) ? M_STREAM : M_IDLE;
                    end
                end
            endcase
            m_valid = do_beat;
            m_stat  = do_beat && h.s;
            m_data  = do_beat ? h.d   : '0;
            m_dst   = do_beat ? h.dst : '0;
            m_vn    = do_beat ? h.vn  : '0;
            if (do_beat) m_icnt = m_icnt + 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                nc.s = cif.i_cmd_stationary; nc.d = cif.i_cmd_data;
                nc.dst = cif.i_cmd_dest; nc.vn = cif.i_cmd_vn;
                mq.push_back(nc);
            end
        end
    end

    task automatic compare_all();
        check_val("data_valid", 512'(cif.o_data_valid), 512'(m_valid));
        check_val("stationary", 512'(cif.o_stationary), 512'(m_stat));
        check_val("data_bus",   512'(cif.o_data_bus),   512'(m_data));
        check_val("dest_bus",   512'(cif.o_dest_bus),   512'(m_dst));
        check_val("vn_sep",     512'(cif.o_vn_seperator), 512'(m_vn));
        check_val("busy",       512'(busy),        512'(m_mode != M_IDLE));
        check_val("fifo_count", 512'(fifo_count),  512'(mq.size()));
        check_val("cmd_ready",  512'(cif.o_cmd_ready), 512'(mq.size() < int'(DEPTH)));
        check_val("issue_cnt",  512'(issue_count), 512'(m_icnt));
        check_val("error",      512'(error),       512'(m_err));
    endtask

    always @(negedge clk) compare_all();

    function automatic logic [511:0] rnd_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cif.i_cmd_valid = 1'b0; cif.i_cmd_stationary = 1'b0;
        cif.i_cmd_data = '0; cif.i_cmd_dest = '0; cif.i_cmd_vn = '0;
        start = 1'b0; stall = 1'b0;
    endtask

    task automatic push_cmd(input logic s, input logic [511:0] d, input logic [511:0] dst);
        logic [511:0] r;
        r = rnd_vec();
        cif.i_cmd_valid = 1'b1; cif.i_cmd_stationary = s;
        cif.i_cmd_data = d; cif.i_cmd_dest = dst[IDX_W-1:0]; cif.i_cmd_vn = r[IDX_W-1:0];
        tick();
        cif.i_cmd_valid = 1'b0;
    endtask

    task automatic push_rand(input logic s);
        push_cmd(s, rnd_vec(), rnd_vec());
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((m_mode != M_IDLE || busy) && n < max_cycles) begin tick(); n++; end
        check_val("idle_wait", 512'(busy), 512'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    endtask

    initial begin
        logic [511:0] s_data, s_dest;
        rst = 1'b0;
        drive_idle();
        tick(); tick();
        check_val("rst_busy", 512'(busy), 512'(0));
        check_val("rst_ready", 512'(cif.o_cmd_ready), 512'(1));
        rst = 1'b1;
        tick();

        // Stationary load followed by five streaming vectors
        for (int i = 0; i < NUM_PES; i++) s_data[i*IN_DATA_TYPE +: IN_DATA_TYPE] = 16'h3F80;
        s_dest = '0;
        s_dest[159:0] = 160'hffbbcdeb38bdab49ca307b9ac5a928398a418820;
        push_cmd(1'b1, s_data, s_dest);
        for (int i = 0; i < 5; i++) push_rand(1'b0);
        pulse_start();
        wait_idle(100);
        check_val("t1_issue", 512'(issue_count), 512'(6));

        // Reload hazard: S,T,T,S,T forces a drain before the second S
        do_reset();
        push_rand(1'b1); push_rand(1'b0); push_rand(1'b0); push_rand(1'b1); push_rand(1'b0);
        pulse_start();
        wait_idle(100);
        check_val("t2_issue", 512'(issue_count), 512'(5));

        // Stall for three cycles mid-stream
        do_reset();
        push_rand(1'b1);
        for (int i = 0; i < 5; i++) push_rand(1'b0);
        pulse_start();
        tick(); tick();
        stall = 1'b1; tick(); tick(); tick(); stall = 1'b0;
        wait_idle(100);
        check_val("t3_issue", 512'(issue_count), 512'(6));

        // Overfill: ninth push must be refused
        do_reset();
        for (int i = 0; i < 9; i++) push_rand(i == 0);
        check_val("t4_full_cnt", 512'(fifo_count), 512'(8));
        check_val("t4_full_rdy", 512'(cif.o_cmd_ready), 512'(0));
        // Push while popping at count 5 keeps occupancy constant
        do_reset();
        push_rand(1'b1);
        for (int i = 0; i < 4; i++) push_rand(1'b0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cif.i_cmd_valid = 1'b1; cif.i_cmd_stationary = 1'b0;
            cif.i_cmd_data = rnd_vec(); tick();
            check_val("t4_pp_cnt", 512'(fifo_count), 512'(5));
        end
        cif.i_cmd_valid = 1'b0;
        wait_idle(100);

        // Streaming command with nothing loaded is discarded and flagged
        do_reset();
        push_rand(1'b0); push_rand(1'b1); push_rand(1'b0);
        pulse_start();
        wait_idle(100);
        check_val("t5_err", 512'(error), 512'(1));
        check_val("t5_issue", 512'(issue_count), 512'(2));

        // Asynchronous reset in the middle of a stream
        do_reset();
        push_rand(1'b1);
        for (int i = 0; i < 5; i++) push_rand(1'b0);
        pulse_start();
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        compare_all();
        check_val("t6_valid", 512'(cif.o_data_valid), 512'(0));
        check_val("t6_cnt", 512'(fifo_count), 512'(0));
        check_val("t6_busy", 512'(busy), 512'(0));
        check_val("t6_issue", 512'(issue_count), 512'(0));
        tick();
        rst = 1'b1;
        tick();
        pulse_start();
        tick();
        check_val("t6_nostart", 512'(busy), 512'(0));

        // Random traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [511:0] r;
            r = rnd_vec();
            cif.i_cmd_valid = ($urandom_range(0, 2) == 0);
            cif.i_cmd_stationary = ($urandom_range(0, 3) == 0);
            cif.i_cmd_data = rnd_vec();
            cif.i_cmd_dest = r[IDX_W-1:0];
            cif.i_cmd_vn = r[2*IDX_W-1:IDX_W];
            start = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 5) == 0);
            if (c % 150 == 0 && c > 0) begin
                stall = 1'b0;
                cif.i_cmd_valid = 1'b1;
                cif.i_cmd_stationary = 1'b1;
            end
            tick();
        end
        drive_idle();
        pulse_start();
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
